// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// Pipeline registers import this package so that the history width and the
// counter encoding stay consistent with the predictor.
package branch_predictor_pkg;

  // Default global history length; the PHT has 2^DEFAULT_BHR_W entries
  localparam int DEFAULT_BHR_W = 10;

  // Default BTB index width; the BTB has 2^DEFAULT_BTB_IDX_W entries
  localparam int DEFAULT_BTB_IDX_W = 5;

  // Widest tag the BTB can need (PC bits above the word offset)
  localparam int BTB_TAG_MAX_W = 30;

  // Two-bit direction counter encoding
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pred_state_t;

  // BTB entry. The tag field is sized for the smallest legal index width;
  // narrower tags are stored zero-extended.
  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_MAX_W-1:0] tag;
    logic [31:0]              target;
    logic                     is_jump;
  } btb_entry_t;

  // Predictor control states
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating up/down counter step.
// Ports:
//   cnt      - current counter value
//   inc      - 1 = count towards strongly taken, 0 = towards strongly not-taken
//   next_cnt - counter value after one step, clamped at 00 and 11
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] next_cnt
);

  always_comb begin
    next_cnt = cnt;
    if (inc) begin
      if (cnt != ST) next_cnt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) next_cnt = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor with a direct-mapped branch target buffer.
// After reset the PHT and BTB valid bits are swept one entry per cycle; ready
// rises once the sweep completes. Lookups are combinational on fetch_pc, and
// training comes from the resolved branch in EX using the pred/bhr snapshots
// that travelled with the instruction.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   fetch_pc        - PC being fetched this cycle
//   predict_taken   - redirect fetch to btb_target next cycle
//   btb_target      - predicted target (0 on BTB miss)
//   btb_hit         - BTB tag match for fetch_pc
//   pred_out        - PHT counter for fetch_pc (to if_id_reg)
//   bhr_out         - current global history (to if_id_reg)
//   upd_*           - resolved control-flow update from EX
//   ready           - init sweep complete
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         BHR_W     = DEFAULT_BHR_W,
  parameter int         BTB_IDX_W = DEFAULT_BTB_IDX_W,
  parameter logic [1:0] PHT_INIT  = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fetch_pc,
  output logic             predict_taken,
  output logic [31:0]      btb_target,
  output logic             btb_hit,
  output logic [1:0]       pred_out,
  output logic [BHR_W-1:0] bhr_out,
  input  logic             upd_valid,
  input  logic             upd_is_br,
  input  logic [31:0]      upd_pc,
  input  logic [BHR_W-1:0] upd_bhr,
  input  logic [1:0]       upd_pred,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  output logic             ready
);

  localparam int PHT_N = 1 << BHR_W;
  localparam int BTB_N = 1 << BTB_IDX_W;

  logic [0:0]       state;
  logic [BHR_W-1:0] sweep_idx;
  logic [BHR_W-1:0] bhr;

  logic [1:0]  pht [PHT_N];
  btb_entry_t  btb [BTB_N];

  logic                     run;
  logic [BHR_W-1:0]         li;
  logic [BTB_IDX_W-1:0]     lb;
  logic [BTB_TAG_MAX_W-1:0] fetch_tag;
  btb_entry_t               look_entry;
  logic                     look_hit;

  logic [BHR_W-1:0]         ui;
  logic [BTB_IDX_W-1:0]     ub;
  logic [BTB_TAG_MAX_W-1:0] upd_tag;
  logic [1:0]               upd_cnt;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign run = (state == S_RUN);

  // Lookup: gshare index into the PHT, PC-indexed BTB. Reads see the array
  // contents before any write on the coming edge, so there is no bypass.
  assign li         = fetch_pc[BHR_W+1:2] ^ bhr;
  assign lb         = fetch_pc[BTB_IDX_W+1:2];
  assign fetch_tag  = BTB_TAG_MAX_W'(fetch_pc >> (BTB_IDX_W + 2));
  assign look_entry = btb[lb];
  assign look_hit   = look_entry.valid && (look_entry.tag == fetch_tag);

  assign btb_hit       = run && look_hit;
  assign pred_out      = run ? pht[li] : PHT_INIT;
  assign btb_target    = btb_hit ? look_entry.target : 32'd0;
  assign predict_taken = btb_hit && (look_entry.is_jump || pred_out[1]);
  assign bhr_out       = run ? bhr : '0;
  assign ready         = run;

  // Update side: the counter base is the snapshot carried down the pipe,
  // not a fresh PHT read.
  assign ui      = upd_pc[BHR_W+1:2] ^ upd_bhr;
  assign ub      = upd_pc[BTB_IDX_W+1:2];
  assign upd_tag = BTB_TAG_MAX_W'(upd_pc >> (BTB_IDX_W + 2));

  sat_counter2 u_sat (
    .cnt      (upd_pred),
    .inc      (upd_taken),
    .next_cnt (upd_cnt)
  );

  // Control: sweep index walks every PHT entry once, then RUN. History only
  // shifts on resolved conditional branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      sweep_idx <= '0;
      bhr       <= '0;
    end else if (state == S_INIT) begin
      sweep_idx <= sweep_idx + 1'b1;
      if (sweep_idx == '1) state <= S_RUN;
    end else if (upd_valid && upd_is_br) begin
      bhr <= {bhr[BHR_W-2:0], upd_taken};
    end
  end

  // Table writes. The BTB index is the low bits of the sweep index, so each
  // BTB entry is invalidated several times during one PHT sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) begin
        pht[sweep_idx] <= PHT_INIT;
        btb[sweep_idx[BTB_IDX_W-1:0]].valid <= 1'b0;
      end else if (upd_valid) begin
        if (upd_is_br) pht[ui] <= upd_cnt;
        if (upd_taken) begin
          btb[ub] <= '{valid:   1'b1,
                       tag:     upd_tag,
                       target:  upd_target,
                       is_jump: ~upd_is_br};
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: init sweep timing, mid-sweep
// reset, branch training, counter saturation, jump handling, BTB aliasing and
// same-cycle lookup/update ordering.
module tb_branch_predictor;

  localparam int BHR_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      fetch_pc;
  logic             predict_taken;
  logic [31:0]      btb_target;
  logic             btb_hit;
  logic [1:0]       pred_out;
  logic [BHR_W-1:0] bhr_out;
  logic             upd_valid;
  logic             upd_is_br;
  logic [31:0]      upd_pc;
  logic [BHR_W-1:0] upd_bhr;
  logic [1:0]       upd_pred;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             ready;

  int checks_total  = 0;
  int checks_passed = 0;

  branch_predictor dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_pc      (fetch_pc),
    .predict_taken (predict_taken),
    .btb_target    (btb_target),
    .btb_hit       (btb_hit),
    .pred_out      (pred_out),
    .bhr_out       (bhr_out),
    .upd_valid     (upd_valid),
    .upd_is_br     (upd_is_br),
    .upd_pc        (upd_pc),
    .upd_bhr       (upd_bhr),
    .upd_pred      (upd_pred),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .ready         (ready)
  );

  always #5 clk = ~clk;

  // One resolved conditional branch and what the tables should hold after it
  typedef struct {
    logic [31:0]      pc;
    logic [BHR_W-1:0] upd_bhr;
    logic [1:0]       upd_pred;
    logic             taken;
    logic [31:0]      target;
    logic [1:0]       exp_pred;
    logic [BHR_W-1:0] exp_bhr;
    logic             exp_hit;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic br, input logic [31:0] pc,
                               input logic [BHR_W-1:0] b, input logic [1:0] p,
                               input logic t, input logic [31:0] tgt);
    upd_valid  = v;
    upd_is_br  = br;
    upd_pc     = pc;
    upd_bhr    = b;
    upd_pred   = p;
    upd_taken  = t;
    upd_target = tgt;
  endtask

  // Fetch PC whose gshare index under history b lands on PHT entry idx
  function automatic logic [31:0] pcFor(input logic [BHR_W-1:0] idx,
                                        input logic [BHR_W-1:0] b);
    logic [BHR_W-1:0] x;
    x = idx ^ b;
    return {20'h0, x, 2'b00};
  endfunction

  // Walk the whole sweep; counts cycles where outputs leave their INIT values.
  // Optionally fires an update in the last few sweep cycles.
  task automatic runSweep(input string name, input logic late_update);
    int bad;
    bad = 0;
    for (int k = 1; k <= 1024; k++) begin
      fetch_pc = 32'(k * 4);
      if (late_update && k >= 1021)
        applyStimulus(1'b1, 1'b1, 32'h100, '0, 2'b01, 1'b1, 32'h200);
      #1;
      if (ready !== 1'b0 || pred_out !== 2'b01 || predict_taken !== 1'b0 ||
          btb_hit !== 1'b0 || bhr_out !== '0 || btb_target !== 32'd0)
        bad++;
      step();
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b0, '0);
    checkOutput({name, "_init_bad_cycles"}, 32'(bad), 32'd0);
    #1;
    checkOutput({name, "_ready_after_1024"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic runVector(input int i);
    vec_t v;
    logic [BHR_W-1:0] ui;
    v  = vecs[i];
    ui = v.pc[BHR_W+1:2] ^ v.upd_bhr;
    applyStimulus(1'b1, 1'b1, v.pc, v.upd_bhr, v.upd_pred, v.taken, v.target);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b0, '0);
    #1;
    checkOutput($sformatf("vec%0d_bhr", i), 32'(bhr_out), 32'(v.exp_bhr));
    fetch_pc = pcFor(ui, v.exp_bhr);
    #1;
    checkOutput($sformatf("vec%0d_pred", i), 32'(pred_out), 32'(v.exp_pred));
    fetch_pc = v.pc;
    #1;
    checkOutput($sformatf("vec%0d_hit", i), 32'(btb_hit), 32'(v.exp_hit));
    checkOutput($sformatf("vec%0d_target", i), btb_target,
                v.exp_hit ? v.target : 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h100, 10'h000, 2'b01, 1'b1, 32'h200, 2'b10, 10'h001, 1'b1};
    vecs[1] = '{32'h100, 10'h000, 2'b01, 1'b1, 32'h200, 2'b10, 10'h003, 1'b1};
    vecs[2] = '{32'h100, 10'h007, 2'b10, 1'b1, 32'h200, 2'b11, 10'h007, 1'b1};
    vecs[3] = '{32'h300, 10'h055, 2'b11, 1'b1, 32'h3A0, 2'b11, 10'h00F, 1'b1};
    vecs[4] = '{32'h304, 10'h000, 2'b00, 1'b0, 32'h3B0, 2'b00, 10'h01E, 1'b0};
    vecs[5] = '{32'h308, 10'h000, 2'b10, 1'b0, 32'h3C0, 2'b01, 10'h03C, 1'b0};
    vecs[6] = '{32'h30C, 10'h000, 2'b01, 1'b0, 32'h3C4, 2'b00, 10'h078, 1'b0};
    vecs[7] = '{32'h310, 10'h000, 2'b10, 1'b1, 32'h3D0, 2'b11, 10'h0F1, 1'b1};

    rst      = 1'b1;
    fetch_pc = '0;
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b0, '0);
    step();
    step();
    rst = 1'b0;

    // Full sweep from reset
    runSweep("reset", 1'b0);

    // Reset partway through a sweep, with an update fired late in INIT
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 500; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    runSweep("midsweep", 1'b1);
    fetch_pc = 32'h100;
    #1;
    checkOutput("midsweep_upd_ignored_hit", 32'(btb_hit), 32'd0);
    checkOutput("midsweep_upd_ignored_pred", 32'(pred_out), 32'h1);
    checkOutput("midsweep_upd_ignored_bhr", 32'(bhr_out), 32'h0);

    // Training at 0x100 and a counter that predicts taken
    for (int i = 0; i < 3; i++) runVector(i);
    fetch_pc = 32'h100;
    #1;
    checkOutput("train_pred_0x100", 32'(pred_out), 32'h3);
    checkOutput("train_hit_0x100", 32'(btb_hit), 32'd1);
    checkOutput("train_target_0x100", btb_target, 32'h200);
    checkOutput("train_taken_0x100", 32'(predict_taken), 32'd1);
    fetch_pc = 32'h11C;
    #1;
    checkOutput("train_pht_0x040", 32'(pred_out), 32'h2);

    // Saturation and not-taken handling
    for (int i = 3; i < 8; i++) runVector(i);

    // jal at 0x400 to 0x800: BTB marks a jump, history and PHT untouched
    applyStimulus(1'b1, 1'b0, 32'h400, 10'h0F1, 2'b01, 1'b1, 32'h800);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b0, '0);
    fetch_pc = 32'h400;
    #1;
    checkOutput("jal_bhr_unchanged", 32'(bhr_out), 32'h0F1);
    checkOutput("jal_pred_unchanged", 32'(pred_out), 32'h1);
    checkOutput("jal_hit", 32'(btb_hit), 32'd1);
    checkOutput("jal_target", btb_target, 32'h800);
    checkOutput("jal_taken", 32'(predict_taken), 32'd1);
    fetch_pc = 32'h480;
    #1;
    checkOutput("alias_hit", 32'(btb_hit), 32'd0);
    checkOutput("alias_taken", 32'(predict_taken), 32'd0);
    checkOutput("alias_target", btb_target, 32'd0);

    // Same-cycle lookup and update of PHT entry 0x1B1
    fetch_pc = 32'h500;
    applyStimulus(1'b1, 1'b1, 32'h500, 10'h0F1, 2'b01, 1'b1, 32'h900);
    #1;
    checkOutput("rbw_pred_old", 32'(pred_out), 32'h1);
    checkOutput("rbw_hit_old", 32'(btb_hit), 32'd0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b0, '0);
    fetch_pc = pcFor(10'h1B1, 10'h1E3);
    #1;
    checkOutput("rbw_bhr_new", 32'(bhr_out), 32'h1E3);
    checkOutput("rbw_pred_new", 32'(pred_out), 32'h2);
    fetch_pc = 32'h500;
    #1;
    checkOutput("rbw_hit_new", 32'(btb_hit), 32'd1);
    checkOutput("rbw_target_new", btb_target, 32'h900);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side gshare direction predictor plus direct-mapped branch target buffer (BTB).
- Sits upstream of if_id_reg and supplies the pred and bhr values that travel down the pipeline with each instruction.
- Looks up the current fetch PC combinationally in the same cycle.
- Is trained by the resolved-branch update from EX, using the pred and bhr snapshots carried through id_ex_reg.

Parameters:
BHR_W, 10, global history length; PHT has 2^BHR_W entries
BTB_IDX_W, 5, BTB index width; BTB has 2^BTB_IDX_W entries
PHT_INIT, 2'b01, counter value written during init sweep (weakly not-taken)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_pc  in  32  PC being fetched this cycle
predict_taken  out  1  redirect fetch to btb_target next cycle
btb_target  out  32  predicted target
btb_hit  out  1  BTB tag match
pred_out  out  2  PHT counter for fetch_pc (to if_id_reg pred_in)
bhr_out  out  BHR_W  current global history (to if_id_reg bhr_in)
upd_valid  in  1  resolved control-flow instruction this cycle
upd_is_br  in  1  1 = conditional branch, 0 = jal/jalr
upd_pc  in  32  PC of resolved instruction
upd_bhr  in  BHR_W  history snapshot carried with that instruction
upd_pred  in  2  counter snapshot carried with that instruction
upd_taken  in  1  resolved direction (1 for jumps)
upd_target  in  32  resolved target
ready  out  1  init sweep complete

Behaviour:
- States: INIT, RUN.
- rst (any cycle, including mid-sweep or mid-RUN):
  - next state INIT, sweep index cleared to 0, bhr cleared to 0.
- INIT: one entry per cycle.
  - PHT[idx] <= PHT_INIT.
  - BTB valid[idx mod 2^BTB_IDX_W] <= 0.
  - idx increments.
  - After idx = 2^BHR_W-1 is written, go to RUN; ready=1 from the following cycle.
  - Sweep length is exactly 2^BHR_W cycles (1024 by default).
- Outputs in INIT:
  - predict_taken=0, btb_hit=0, pred_out=PHT_INIT, bhr_out=0, btb_target=0, ready=0.
  - upd_valid is ignored.
- Lookup in RUN (combinational, zero latency):
  - Index: li = fetch_pc[BHR_W+1:2] XOR bhr. pred_out = PHT[li].
  - BTB entry: fetch_pc[BTB_IDX_W+1:2].
  - btb_hit = valid AND tag == fetch_pc[31:BTB_IDX_W+2].
  - btb_target = stored target when hit, else 0.
  - predict_taken = btb_hit AND (stored is_jump OR pred_out[1]).
- Update in RUN (on upd_valid, effective at the next edge):
  - Conditional branch (upd_is_br=1):
    - ui = upd_pc[BHR_W+1:2] XOR upd_bhr.
    - PHT[ui] <= saturating upd_pred+1 if taken, else upd_pred-1. Saturates at 2'b11 and 2'b00.
    - bhr <= {bhr[BHR_W-2:0], upd_taken}.
  - Any control-flow instruction with upd_taken=1: write the BTB entry at upd_pc index with valid=1, tag, upd_target, and is_jump=~upd_is_br. This overwrites any existing entry.
  - Not-taken branch: BTB untouched.
  - Jumps (upd_is_br=0): PHT and bhr untouched.
- Same-cycle lookup and update to the same PHT/BTB entry: the lookup returns the pre-update value (read-before-write, no bypass).
- bhr_out equals the registered bhr. An update to it is visible the cycle after upd_valid.
- upd_pred is trusted as the counter base; the PHT is not re-read on update.

Decomposition:
- Shared package entries:
  - pred_state_t enum: SNT=00, WNT=01, WT=10, ST=11.
  - BHR_W default constant, so pipeline registers share the width.
  - btb_entry_t struct: valid, tag, target, is_jump.
- One natural sub-module: sat_counter2, the 2-bit saturating increment/decrement function or module.
- The PHT and BTB arrays stay in the top module.

Test Plan:
- rst for 1 cycle, then idle: ready=0 for exactly 1024 cycles, 1 on cycle 1025; pred_out=01 and predict_taken=0 throughout INIT.
- Mid-sweep reset: assert rst at sweep cycle 500. The sweep restarts; ready rises 1024 cycles after rst deasserts. An upd_valid issued during INIT has no effect.
- Training a branch:
  - Setup: pc=0x100, bhr=0; update taken, target 0x200, upd_pred=01, twice.
  - After the first update: bhr=0x001. After the second: bhr=0x003.
  - Lookup of pc 0x100 with upd_pred chain 01→10→11: PHT index 0x040 holds 10, so btb_hit=1, btb_target=0x200.
  - predict_taken=1 when the XOR index maps to a trained counter.
- Saturation: update with upd_pred=11, taken gives 11; upd_pred=00, not-taken gives 00; upd_pred=10, not-taken gives 01.
- jal at 0x400 to 0x800, upd_is_br=0:
  - BTB is_jump=1, and a lookup of 0x400 gives predict_taken=1 regardless of the counter.
  - bhr is unchanged.
  - A BTB alias at 0x480 (same index, different tag) gives btb_hit=0.
- Same-cycle lookup and update of the same index: pred_out shows the old counter this cycle and the new value next cycle.
